// File: rtl/seg7_decoder_nd_if.sv
// Bundle for the seven-segment readback decoder: raw patterns in, committed word plus handshake out.
// The decimal-point output exists only when SEG7_DP_EN is defined.
interface seg7_decoder_nd_if #(
    parameter int NUM_DIGITS = 4
);
`ifdef SEG7_DP_EN
    localparam int SEGW = 8;
`else
    localparam int SEGW = 7;
`endif

    logic [SEGW*NUM_DIGITS-1:0] iSEG;
    logic [4*NUM_DIGITS-1:0]    oDIG;
    logic [NUM_DIGITS-1:0]      oDIG_OK;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]      oDP;
`endif
    logic                       oVALID;
    logic                       iREADY;
    logic                       oOVERRUN;
    logic                       iCLR_OVR;

    modport master (
        output iSEG, iREADY, iCLR_OVR,
        input  oDIG, oDIG_OK,
`ifdef SEG7_DP_EN
        input  oDP,
`endif
        input  oVALID, oOVERRUN
    );

    modport slave (
        input  iSEG, iREADY, iCLR_OVR,
        output oDIG, oDIG_OK,
`ifdef SEG7_DP_EN
        output oDP,
`endif
        output oVALID, oOVERRUN
    );
endinterface

// File: rtl/seg7_decoder_nd.sv
// Debounced multi-digit active-low seven-segment to hex decoder with valid/ready and sticky overrun.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_decoder_nd #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic              iCLK,
    input logic              iRST,
    seg7_decoder_nd_if.slave bus
);
`ifdef SEG7_DP_EN
    localparam int SEGW = 8;
    localparam int WW   = 6;
`else
    localparam int SEGW = 7;
    localparam int WW   = 5;
`endif
    localparam int            CW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LP_CMT = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LP_SAT = CW'(STABLE_CYCLES);

    // Returns {ok, nibble}; anything outside the sixteen glyphs decodes to {0, 0}.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = 5'h10;
            7'b1111001: res = 5'h11;
            7'b0100100: res = 5'h12;
            7'b0110000: res = 5'h13;
            7'b0011001: res = 5'h14;
            7'b0010010: res = 5'h15;
            7'b0000010: res = 5'h16;
            7'b1111000: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0011000: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b0000011: res = 5'h1B;
            7'b1000110: res = 5'h1C;
            7'b0100001: res = 5'h1D;
            7'b0000110: res = 5'h1E;
            7'b0001110: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    logic [NUM_DIGITS-1:0]   w_chg;
    logic [4*NUM_DIGITS-1:0] w_dig;
    logic [NUM_DIGITS-1:0]   w_ok;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   w_dp;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [SEGW-1:0] r_cap;
            logic [CW-1:0]   r_cnt;
            logic [WW-1:0]   r_word;
            logic [SEGW-1:0] w_in;
            logic            w_match;
            logic            w_commit;
            logic [WW-1:0]   w_new;

            assign w_in     = bus.iSEG[gi*SEGW +: SEGW];
            assign w_match  = (w_in == r_cap);
            assign w_commit = w_match && (r_cnt == LP_CMT);
`ifdef SEG7_DP_EN
            assign w_new    = {~r_cap[7], f_decode(r_cap[6:0])};
            assign w_dp[gi] = r_word[5];
`else
            assign w_new    = f_decode(r_cap[6:0]);
`endif
            // Only commits that actually alter the visible word count as a change.
            assign w_chg[gi]          = w_commit && (w_new != r_word);
            assign w_dig[gi*4 +: 4]   = r_word[3:0];
            assign w_ok[gi]           = r_word[4];

            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    r_cap  <= {SEGW{1'b1}};
                    r_cnt  <= '0;
                    r_word <= '0;
                end else begin
                    r_cap <= w_in;
                    if (!w_match)
                        r_cnt <= '0;
                    else if (r_cnt != LP_SAT)
                        r_cnt <= r_cnt + 1'b1;
                    if (w_commit)
                        r_word <= w_new;
                end
            end
        end
    endgenerate

    logic w_change;
    logic r_chg;
    logic r_valid;
    logic r_ovr;

    assign w_change = |w_chg;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_chg   <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_chg <= w_change;
            // A change on the acknowledging edge keeps the word pending.
            if (r_chg)
                r_valid <= 1'b1;
            else if (r_valid && bus.iREADY && !w_change)
                r_valid <= 1'b0;
            if (w_change && r_valid && !bus.iREADY)
                r_ovr <= 1'b1;
            else if (bus.iCLR_OVR)
                r_ovr <= 1'b0;
        end
    end

    assign bus.oDIG     = w_dig;
    assign bus.oDIG_OK  = w_ok;
`ifdef SEG7_DP_EN
    assign bus.oDP      = w_dp;
`endif
    assign bus.oVALID   = r_valid;
    assign bus.oOVERRUN = r_ovr;
endmodule

// File: tb/tb_seg7_decoder_nd.sv
// Bench for seg7_decoder_nd: directed test-plan steps plus random holds, checked against a run-length model.
module tb_seg7_decoder_nd;
    localparam int ND = 4;
    localparam int S  = 4;
`ifdef SEG7_DP_EN
    localparam int SEGW = 8;
`else
    localparam int SEGW = 7;
`endif

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    seg7_decoder_nd_if #(.NUM_DIGITS(ND)) u_if ();
    seg7_decoder_nd #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (u_if.slave)
    );

    always #5 iCLK = ~iCLK;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference state: how long each digit's input has been held, and the committed word.
    logic [SEGW-1:0] m_prev [ND];
    int              m_run  [ND];
    logic [3:0]      m_nib  [ND];
    logic            m_ok   [ND];
    logic            m_dp   [ND];
    logic            m_pend, m_valid, m_ovr;

    function automatic logic [SEGW-1:0] mk(input logic [6:0] g);
        logic [SEGW-1:0] v;
        v      = {SEGW{1'b1}};
        v[6:0] = g;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_prev[d] = {SEGW{1'b1}};
            m_run[d]  = 1;
            m_nib[d]  = 4'h0;
            m_ok[d]   = 1'b0;
            m_dp[d]   = 1'b0;
        end
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge();
        logic            chg;
        logic [SEGW-1:0] v;
        logic [3:0]      nib;
        logic            ok, dp;
        chg = 1'b0;
        for (int d = 0; d < ND; d++) begin
            v = u_if.iSEG[d*SEGW +: SEGW];
            if (v == m_prev[d]) m_run[d] = (m_run[d] < 1000) ? m_run[d] + 1 : m_run[d];
            else                m_run[d] = 1;
            m_prev[d] = v;
            if (m_run[d] == S + 1) begin
                nib = 4'h0;
                ok  = 1'b0;
                for (int k = 0; k < 16; k++)
                    if (glyph[k] == v[6:0]) begin nib = 4'(k); ok = 1'b1; end
`ifdef SEG7_DP_EN
                dp = ~v[7];
`else
                dp = 1'b0;
`endif
                if (nib != m_nib[d] || ok != m_ok[d] || dp != m_dp[d]) chg = 1'b1;
                m_nib[d] = nib;
                m_ok[d]  = ok;
                m_dp[d]  = dp;
            end
        end
        if (m_valid && u_if.iREADY)
            $display("word handshake t=%0t ack=%0d", $time, !chg && !m_pend);
        if (chg && m_valid && !u_if.iREADY) m_ovr = 1'b1;
        else if (u_if.iCLR_OVR)             m_ovr = 1'b0;
        if (m_pend)                                  m_valid = 1'b1;
        else if (m_valid && u_if.iREADY && !chg)     m_valid = 1'b0;
        m_pend = chg;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all();
        logic [4*ND-1:0] e_dig;
        logic [ND-1:0]   e_ok, e_dp;
        for (int d = 0; d < ND; d++) begin
            e_dig[d*4 +: 4] = m_nib[d];
            e_ok[d]         = m_ok[d];
            e_dp[d]         = m_dp[d];
        end
        chk("oDIG", 32'(u_if.oDIG), 32'(e_dig));
        chk("oDIG_OK", 32'(u_if.oDIG_OK), 32'(e_ok));
        chk("oVALID", 32'(u_if.oVALID), 32'(m_valid));
        chk("oOVERRUN", 32'(u_if.oOVERRUN), 32'(m_ovr));
`ifdef SEG7_DP_EN
        chk("oDP", 32'(u_if.oDP), 32'(e_dp));
`else
        if (e_dp != '0) chk("model_dp", 32'(e_dp), 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge iCLK);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic set_digit(input int d, input logic [SEGW-1:0] v);
        u_if.iSEG[d*SEGW +: SEGW] = v;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int              rd, rsel, rhold;
    logic [6:0]      rg;
    logic [SEGW-1:0] rv;

    initial begin
        u_if.iSEG     = {(SEGW*ND){1'b1}};
        u_if.iREADY   = 1'b0;
        u_if.iCLR_OVR = 1'b0;
        model_reset();
        #1 iRST = 1'b1;
        #1;
        chk("rst_dig", 32'(u_if.oDIG), 32'h0);
        chk("rst_ok", 32'(u_if.oDIG_OK), 32'h0);
        chk("rst_valid", 32'(u_if.oVALID), 32'h0);
        chk("rst_ovr", 32'(u_if.oOVERRUN), 32'h0);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;

        // Digits 3..0 = 0,2,3,1
        set_digit(3, mk(glyph[0]));
        set_digit(2, mk(glyph[2]));
        set_digit(1, mk(glyph[3]));
        set_digit(0, mk(glyph[1]));
        ticks(4);
        chk("tp_dig_early", 32'(u_if.oDIG), 32'h0);
        tick();
        chk("tp_dig", 32'(u_if.oDIG), 32'h0231);
        chk("tp_ok", 32'(u_if.oDIG_OK), 32'hF);
        chk("tp_valid_early", 32'(u_if.oVALID), 32'h0);
        tick();
        chk("tp_valid", 32'(u_if.oVALID), 32'h1);
        u_if.iREADY = 1'b1;
        tick();
        u_if.iREADY = 1'b0;
        chk("tp_ack", 32'(u_if.oVALID), 32'h0);

        // Glitchy digit 0 never requalifies
        for (int i = 0; i < 10; i++) begin
            set_digit(0, mk((i % 2 == 0) ? glyph[4] : glyph[1]));
            ticks(2);
        end
        chk("glitch_dig0", 32'(u_if.oDIG[3:0]), 32'h1);
        chk("glitch_valid", 32'(u_if.oVALID), 32'h0);
        ticks(6);

        // Blank digit 2
        set_digit(2, mk(7'h7F));
        ticks(6);
        chk("blank_dig2", 32'(u_if.oDIG[11:8]), 32'h0);
        chk("blank_ok", 32'(u_if.oDIG_OK), 32'hB);

        // Overrun while pending
        set_digit(1, mk(glyph[10]));
        ticks(6);
        chk("ovr_dig1", 32'(u_if.oDIG[7:4]), 32'hA);
        chk("ovr_valid", 32'(u_if.oVALID), 32'h1);
        chk("ovr_set", 32'(u_if.oOVERRUN), 32'h1);
        set_digit(3, mk(glyph[8]));
        ticks(4);
        u_if.iCLR_OVR = 1'b1;
        tick();
        chk("ovr_set_wins", 32'(u_if.oOVERRUN), 32'h1);
        tick();
        u_if.iCLR_OVR = 1'b0;
        chk("ovr_clr", 32'(u_if.oOVERRUN), 32'h0);

        // Ready on the commit edge keeps the word valid
        set_digit(0, mk(glyph[7]));
        ticks(4);
        u_if.iREADY = 1'b1;
        tick();
        chk("rdy_commit_valid", 32'(u_if.oVALID), 32'h1);
        chk("rdy_commit_dig0", 32'(u_if.oDIG[3:0]), 32'h7);
        ticks(2);
        u_if.iREADY = 1'b0;

`ifdef SEG7_DP_EN
        begin
            logic [7:0] dpv;
            dpv = {1'b0, glyph[1]};
            set_digit(0, dpv);
            ticks(6);
            chk("dp_on_dig0", 32'(u_if.oDIG[3:0]), 32'h1);
            chk("dp_on", 32'(u_if.oDP[0]), 32'h1);
            u_if.iREADY = 1'b1;
            ticks(2);
            dpv[7] = 1'b1;
            set_digit(0, dpv);
            ticks(5);
            chk("dp_off", 32'(u_if.oDP[0]), 32'h0);
            tick();
            chk("dp_word", 32'(u_if.oVALID), 32'h1);
            tick();
            u_if.iREADY = 1'b0;
        end
`endif

        // Randomized holds across digits
        for (int s = 0; s < 80; s++) begin
            rd   = $urandom_range(0, ND - 1);
            rsel = $urandom_range(0, 9);
            if (rsel < 8)       rg = glyph[$urandom_range(0, 15)];
            else if (rsel == 8) rg = 7'h7F;
            else                rg = 7'($urandom);
            rv = mk(rg);
`ifdef SEG7_DP_EN
            rv[7] = 1'($urandom_range(0, 1));
`endif
            set_digit(rd, rv);
            rhold = $urandom_range(1, 8);
            for (int h = 0; h < rhold; h++) begin
                u_if.iREADY   = ($urandom_range(0, 2) == 0);
                u_if.iCLR_OVR = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        u_if.iREADY   = 1'b0;
        u_if.iCLR_OVR = 1'b0;

        // Reset in the middle of a count
        set_digit(2, mk(glyph[9]));
        ticks(2);
        #2 iRST = 1'b1;
        #1;
        chk("mid_rst_dig", 32'(u_if.oDIG), 32'h0);
        chk("mid_rst_ok", 32'(u_if.oDIG_OK), 32'h0);
        chk("mid_rst_valid", 32'(u_if.oVALID), 32'h0);
        chk("mid_rst_ovr", 32'(u_if.oOVERRUN), 32'h0);
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        ticks(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seg7_decoder_nd.md
# seg7_decoder_nd

Parametrised, debounced multi-digit decoder that turns N captured active-low seven-segment patterns back into hex nibbles for the smart-home controller's display-readback path. Each digit has its own stability filter, so a pattern is committed only after it has been held for a programmable number of cycles. Undecodable patterns are flagged per digit instead of being silently mapped to zero. Committed words go to the consumer over a valid/ready handshake with a sticky overrun flag.

## Interface
- NUM_DIGITS, 4: number of digits decoded; must be 1–8.
- STABLE_CYCLES, 4: consecutive identical captures required before a digit commits; must be 1–255.
- SEGW (derived, not overridable): 8 with SEG7_DP_EN, otherwise 7.

- iCLK  in  1  system clock.
- iRST  in  1  asynchronous, active-high reset.
- iSEG  in  SEGW*NUM_DIGITS  raw patterns, digit 0 in the LSBs; segments a..g in bits [6:0], active-low; bit 7 is DP when SEG7_DP_EN is defined.
- oDIG  out  4*NUM_DIGITS  committed hex nibbles, digit 0 in the LSBs.
- oDIG_OK  out  NUM_DIGITS  1 = committed pattern is a legal 0–F glyph.
- oDP  out  NUM_DIGITS  committed decimal points, active-high; present only with SEG7_DP_EN.
- oVALID  out  1  new committed word available.
- iREADY  in  1  consumer accepts the word.
- oOVERRUN  out  1  sticky: a word was replaced while still pending.
- iCLR_OVR  in  1  synchronous clear of oOVERRUN.

## Operation
- Glyph map, on bits [6:0]:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Any other pattern, including blank 1111111: nibble 0, OK = 0.
- Per-digit filter (one instance per digit):
  - Capture register `cap` loads iSEG every edge.
  - Counter `cnt` is clog2(STABLE_CYCLES+1) bits.
  - If the new input differs from `cap`: `cnt` ← 0.
  - Otherwise `cnt` increments, saturating at STABLE_CYCLES.
  - When `cnt` reaches STABLE_CYCLES-1 and the input still matches `cap`, the digit commits: oDIG nibble, oDIG_OK bit and oDP bit load the decode of `cap`.
  - A saturated counter never re-commits.
  - A new pattern must requalify from zero.
- Word change: any commit edge that alters oDIG, oDIG_OK or oDP. A commit of an identical value is not a change.
- Handshake:
  - oVALID sets on the edge after a word change.
  - oVALID clears on an edge with oVALID=1 and iREADY=1, unless a word change occurs on that same edge, in which case it stays 1.
  - The word is live: the consumer always reads the latest committed value. There is no FIFO.
- Overrun:
  - Sets when a word change occurs while oVALID=1 and iREADY=0.
  - iCLR_OVR clears it. If set and clear coincide, set wins.
- All digits filter independently. Simultaneous commits in several digits produce one word change.

## Timing
- Reset (async assert, sync deassert handled externally):
  - `cap` = all ones, `cnt` = 0.
  - oDIG = 0, oDIG_OK = 0, oDP = 0.
  - oVALID = 0, oOVERRUN = 0.
- Latency: a pattern stable at iSEG from before edge E0 appears on oDIG after edge E0+STABLE_CYCLES. oVALID rises after edge E0+STABLE_CYCLES+1.
- STABLE_CYCLES=1: commit on the second consecutive matching capture, so latency is 1 edge after capture.
- A glitch of fewer than STABLE_CYCLES+1 edges never reaches oDIG.
- Reset mid-filter discards partial counts. Reset with oVALID=1 drops the pending word with no overrun.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SEG7_DP_EN:
  - Defined: SEGW=8 and bit 7 of each digit is DP, active-low at the input. DP is part of the stability compare and of the change detect. oDP reports DP active-high.
  - Undefined: SEGW=7, no oDP port, and DP logic is removed.

## Test plan
- Reset, then drive iSEG=1000000_0100100_0110000_1111001 (digits 3..0 = 0,2,3,1) with N=4, S=4 and hold → oDIG=16'h0231, oDIG_OK=4'hF after edge 4; oVALID=1 after edge 5; iREADY=1 for one cycle → oVALID=0.
- Digit 0 toggles 1111001↔0011001 every 2 cycles for 20 cycles → oDIG[3:0] stays 1 and oVALID stays 0.
- Digit 2 = 1111111 (blank), others legal → oDIG[11:8]=0, oDIG_OK=4'b1011.
- With oVALID=1 and iREADY=0, change digit 1 to 0001000 and hold → oDIG[7:4]=A, oVALID stays 1, oOVERRUN=1; iCLR_OVR and a new change on the same edge → oOVERRUN stays 1.
- iREADY=1 on the same edge as a new commit → oVALID remains 1 and shows the new word; assert iRST mid-count → all outputs 0 immediately.
- SEG7_DP_EN defined, digit 0 = 0_1111001 (DP on) held 5 edges → oDIG[3:0]=1, oDP[0]=1; only the DP bit then toggles and is held → one new word with oDP[0]=0.
